// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and transmitter/receiver FSM states.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with a show-ahead head and an extra level bit
// so that full and empty are never confused.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed from an AXI-Stream byte port through a small FIFO;
// frames go out LSB-first with no idle gap between back-to-back bytes.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             ss_tvalid,
  input  logic [7:0]       ss_tdata,
  output logic             ss_tready,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e                state, state_d;
  logic [DIV_W-1:0]           baud_cnt, baud_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [BIT_W-1:0]           bit_cnt, bit_d;
  logic [UART_DATA_BITS-1:0]  shreg, shreg_d;
  logic                       tx_q, tx_d;
  logic                       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0]                 fifo_rdata;
  logic                       baud_tc, start_frame;
  logic [DIV_W-1:0]           eff_div;

  assign ss_tready = !fifo_full;
  assign fifo_push = ss_tvalid && ss_tready;
  assign eff_div   = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign baud_tc   = (baud_cnt == div_q - 1'b1);
  assign tx        = tx_q;
  assign busy      = (state != IDLE) || (fifo_level != '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock (axis_clk),
    .rst_n (axis_rst_n),
    .push  (fifo_push),
    .wdata (ss_tdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state;
    baud_d      = baud_cnt;
    div_d       = div_q;
    bit_d       = bit_cnt;
    shreg_d     = shreg;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg[0];
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_cnt == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shreg_d = shreg >> 1;
            tx_d    = shreg[1];
            bit_d   = bit_cnt + 1'b1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (!fifo_empty) start_frame = 1'b1;
          else state_d = IDLE;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The divider is sampled only here, so a mid-frame change waits for the next byte.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shreg_d  = fifo_rdata;
      div_d    = eff_div;
      baud_d   = '0;
      tx_d     = 1'b0;
      state_d  = START;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_q    <= DIV_W'(1);
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      div_q    <= div_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: table of single-byte frames plus
// directed burst, reset-abort and push-on-pop sequences, with a line decoder.
`timescale 1ns/1ps
module tb_uart_tx_stream;

  logic        axis_clk   = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        ss_tvalid  = 1'b0;
  logic [7:0]  ss_tdata   = 8'h00;
  logic        ss_tready;
  logic [15:0] clk_div    = 16'd4;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  uart_tx_stream #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tready  (ss_tready),
    .clk_div    (clk_div),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #12.5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  // Line decoder: samples tx 1 ns after each edge, mid-bit, using mon_div.
  int         mon_div = 4;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         stop_err = 0;
  bit         in_frame = 1'b0;
  int         fc, fd;
  logic [7:0] sh;

  always @(posedge axis_clk) begin
    #1;
    if (!axis_rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame = 1'b1;
        fc = 0;
        fd = mon_div;
        sh = 8'h00;
        start_q.push_back(cyc);
      end
    end else begin
      fc++;
      for (int i = 1; i <= 8; i++)
        if (fc == i * fd + fd / 2) sh[i-1] = tx;
      if (fc == 9 * fd + fd / 2) begin
        if (tx !== 1'b1) stop_err++;
        rx_q.push_back(sh);
      end
      if (fc == 10 * fd - 1) in_frame = 1'b0;
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [15:0] div, output int push_cyc);
    ss_tdata  = data;
    clk_div   = div;
    mon_div   = (div == 16'd0) ? 1 : int'(div);
    ss_tvalid = 1'b1;
    tick();
    push_cyc  = cyc;
    ss_tvalid = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) checkOutput("busy timeout", 0, 1);
  endtask

  logic [7:0] burst_q[$];

  task automatic pushBurst(output int first_cyc);
    int  acc;
    bit  rdy;
    acc       = 0;
    first_cyc = -1;
    ss_tdata  = burst_q[0];
    ss_tvalid = 1'b1;
    for (int g = 0; g < 2000 && acc < burst_q.size(); g++) begin
      rdy = ss_tready;
      tick();
      if (rdy) begin
        if (acc == 0) first_cyc = cyc;
        acc++;
        if (acc == 5) begin
          checkOutput("tready low when full", ss_tready, 0);
          checkOutput("level when full", fifo_level, 4);
        end
        if (acc < burst_q.size()) ss_tdata = burst_q[acc];
      end
    end
    ss_tvalid = 1'b0;
    if (acc != burst_q.size()) checkOutput("burst accept count", acc, burst_q.size());
  endtask

  function automatic int startAt(input int idx);
    return (idx < start_q.size()) ? start_q[idx] : -1;
  endfunction

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    bit          mid_chg;
    logic [15:0] mid_div;
    int          bit_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int push_cyc, fall, first, s0;
    logic [7:0] exp_b[$];
    int lows;

    vecs[0] = '{8'hA5, 16'd4, 1'b0, 16'd0, 4};
    vecs[1] = '{8'h00, 16'd0, 1'b0, 16'd0, 1};
    vecs[2] = '{8'hFF, 16'd1, 1'b0, 16'd0, 1};
    vecs[3] = '{8'h3C, 16'd4, 1'b1, 16'd7, 4};
    vecs[4] = '{8'h81, 16'd7, 1'b0, 16'd0, 7};
    vecs[5] = '{8'h5A, 16'd2, 1'b0, 16'd0, 2};

    // Reset and idle.
    tick();
    checkOutput("tx in reset", tx, 1);
    repeat (2) tick();
    axis_rst_n = 1'b1;
    repeat (20) tick();
    checkOutput("idle tx", tx, 1);
    checkOutput("idle tready", ss_tready, 1);
    checkOutput("idle busy", busy, 0);
    checkOutput("idle level", fifo_level, 0);

    // Single frames from the vector table.
    foreach (vecs[k]) begin
      rx_q.delete();
      start_q.delete();
      applyStimulus(vecs[k].data, vecs[k].div, push_cyc);
      if (vecs[k].mid_chg) begin
        repeat (6) tick();
        clk_div = vecs[k].mid_div;
      end
      waitIdle(20 * vecs[k].bit_cyc + 20, fall);
      if (rx_q.size() == 0) checkOutput("frame decoded", 0, 1);
      else checkOutput("frame byte", rx_q[0], vecs[k].data);
      checkOutput("start latency", startAt(0) - push_cyc, 1);
      checkOutput("frame length", fall - startAt(0), 10 * vecs[k].bit_cyc);
      checkOutput("tx idle after frame", tx, 1);
    end

    // Burst of six with tvalid held high.
    clk_div = 16'd4;
    mon_div = 4;
    rx_q.delete();
    start_q.delete();
    burst_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    pushBurst(first);
    waitIdle(400, fall);
    checkOutput("burst frame count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      checkOutput("burst byte order", rx_q[i], burst_q[i]);
    checkOutput("burst first latency", startAt(0) - first, 1);
    for (int i = 1; i < 6; i++)
      checkOutput("burst frame spacing", startAt(i) - startAt(i-1), 40);

    // Reset in the middle of a DATA bit with three bytes still queued.
    rx_q.delete();
    start_q.delete();
    burst_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    pushBurst(first);
    while (cyc < first + 1 + 4 + 6) tick();
    checkOutput("tx low mid data", tx, 0);
    checkOutput("level before reset", fifo_level, 3);
    #3;
    axis_rst_n = 1'b0;
    #1;
    checkOutput("tx on async reset", tx, 1);
    checkOutput("level on reset", fifo_level, 0);
    checkOutput("busy on reset", busy, 0);
    repeat (2) tick();
    axis_rst_n = 1'b1;
    rx_q.delete();
    start_q.delete();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    checkOutput("no frame after reset", lows, 0);
    checkOutput("nothing decoded after reset", rx_q.size(), 0);
    checkOutput("level after reset", fifo_level, 0);
    checkOutput("busy after reset", busy, 0);

    // Push on the exact cycle of a pop while three bytes are queued.
    rx_q.delete();
    start_q.delete();
    burst_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pushBurst(first);
    s0 = first + 1;
    for (int g = 0; g < 200 && cyc < s0 + 39; g++) tick();
    checkOutput("level before push-pop", fifo_level, 3);
    checkOutput("tready before push-pop", ss_tready, 1);
    ss_tdata  = 8'h55;
    ss_tvalid = 1'b1;
    tick();
    ss_tvalid = 1'b0;
    checkOutput("level after push-pop", fifo_level, 3);
    waitIdle(400, fall);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    checkOutput("push-pop frame count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      checkOutput("push-pop byte order", rx_q[i], exp_b[i]);
    checkOutput("second frame start", startAt(1) - s0, 40);

    checkOutput("stop bit errors", stop_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
